axis_serial_loader: RTL



---
 rtl/axis_serial_loader_if.sv | 11 +
 rtl/axis_serial_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/axis_serial_loader_if.sv
// AXI4-Stream slave channel carrying serial-loader frame words.
interface axis_serial_loader_if #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_serial_loader.sv
// AXI4-Stream word to serial shift-register frame, followed by a latch-load strobe.
// Frame: DATA_WIDTH bit periods, then one load period; every period is 2*HALF_PERIOD aclk cycles.
module axis_serial_loader #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned LOAD_WIDTH       = 2,
  parameter int unsigned HALF_PERIOD      = 64,
  parameter bit          MSB_FIRST        = 1'b1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_serial_loader_if.slave   s_axis,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic [LOAD_WIDTH-1:0] ser_load,
  output logic                  busy
);

  localparam int unsigned HW = $clog2(HALF_PERIOD);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 1 || HALF_PERIOD < 2 || DATA_WIDTH + LOAD_WIDTH > AXIS_TDATA_WIDTH) begin : g_bad_params
    $error("axis_serial_loader: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                state;
  logic [HW-1:0]         hcnt;
  logic [BW-1:0]         bcnt;
  logic                  phase;
  logic [DATA_WIDTH-1:0] sreg;
  logic [LOAD_WIDTH-1:0] mask;
  logic                  tready_q;

  logic                  accept;
  logic                  first_bit;
  logic [DATA_WIDTH-1:0] sreg_next;
  logic                  next_bit;

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid & tready_q;

  always_comb begin
    first_bit = MSB_FIRST ? s_axis.tdata[DATA_WIDTH-1] : s_axis.tdata[0];
    sreg_next = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
    next_bit  = MSB_FIRST ? sreg_next[DATA_WIDTH-1] : sreg_next[0];
  end

  // phase selects the half of the current period; ser_clk and ser_load are
  // updated on the edge that enters the second half so they stay registered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      hcnt     <= '0;
      bcnt     <= '0;
      phase    <= 1'b0;
      sreg     <= '0;
      mask     <= '0;
      tready_q <= 1'b0;
      ser_data <= 1'b0;
      ser_clk  <= 1'b0;
      ser_load <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hcnt     <= '0;
          bcnt     <= '0;
          phase    <= 1'b0;
          ser_clk  <= 1'b0;
          ser_load <= '0;
          if (accept) begin
            sreg     <= s_axis.tdata[DATA_WIDTH-1:0];
            mask     <= s_axis.tdata[DATA_WIDTH+LOAD_WIDTH-1:DATA_WIDTH];
            ser_data <= first_bit;
            tready_q <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            ser_data <= 1'b0;
            tready_q <= 1'b1;
            busy     <= 1'b0;
          end
        end

        SHIFT: begin
          if (hcnt != HALF_LAST) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (!phase) begin
              phase   <= 1'b1;
              ser_clk <= 1'b1;
            end else begin
              phase   <= 1'b0;
              ser_clk <= 1'b0;
              if (bcnt == BIT_LAST) begin
                bcnt     <= '0;
                ser_data <= 1'b0;
                state    <= LOAD;
              end else begin
                bcnt     <= bcnt + 1'b1;
                sreg     <= sreg_next;
                ser_data <= next_bit;
              end
            end
          end
        end

        LOAD: begin
          if (hcnt != HALF_LAST) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (!phase) begin
              phase    <= 1'b1;
              ser_load <= mask;
            end else begin
              phase    <= 1'b0;
              ser_load <= '0;
              busy     <= 1'b0;
              tready_q <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
